hq2x_scan_ctrl: RTL

Front-end timing controller that sits directly upstream of the Hq2x scaler.
- Measures the input pixel period and the input line geometry.
- Generates the Hq2x control set: ce_in at 4x pixel rate, ce_out at 2x pixel rate, reset_line, reset_frame, read_y and output hblank.
- Produces doubled-rate output sync (two output lines per input line).

---
 rtl/hq2x_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/hq2x_scan_ctrl.sv
// hq2x_scan_ctrl: timing front-end for the Hq2x scaler.
// Measures pixel period and line geometry, drives scaler strobes and 2x sync.
//
// Ports: clk/reset (sync, active high); ce_pix, hs_in, vs_in, hblank_in,
// vblank_in, rgb_in from the source. inputpixel, ce_in (4x), ce_out (2x),
// reset_line, reset_frame, read_y to the scaler. hblank_out, hs_out,
// vs_out, vblank_out for the doubled output. mode_err flags P < 8.
// Optional HQ2X_SCAN_STATS_EN adds stat_period, stat_line_len, stat_lines.
module hq2x_scan_ctrl #(
  parameter int HWIDTH = 12,
  parameter int PWIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic [23:0] rgb_in,
  output logic [23:0] inputpixel,
  output logic        ce_in,
  output logic        reset_line,
  output logic        reset_frame,
  output logic        ce_out,
  output logic [1:0]  read_y,
  output logic        hblank_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        vblank_out,
  output logic        mode_err
`ifdef HQ2X_SCAN_STATS_EN
  ,
  output logic [PWIDTH-1:0] stat_period,
  output logic [HWIDTH-1:0] stat_line_len,
  output logic [HWIDTH-1:0] stat_lines
`endif
);

  localparam logic [PWIDTH-1:0] PMAX = '1;
  localparam logic [PWIDTH-1:0] ONE_P = 1;
  localparam logic [PWIDTH-1:0] PMIN = 8;
  localparam logic [HWIDTH-1:0] HMAX = '1;
  localparam logic [HWIDTH-1:0] ONE_H = 1;
  localparam logic [PWIDTH:0]   ONE_W = 1;

  logic [PWIDTH-1:0] cnt, per, pnext, q1, hf, q3;
  logic [PWIDTH:0]   ph;
  logic              pix_seen, per_vld, merr;
  logic              in_win, hit4, hit2, cei, ceo;
  logic [23:0]       pix_q;
  logic              rl_q, rf_q, hb_p, hs_p;
  logic [HWIDTH-1:0] hpos, cur, len, act, hs0, hs1;
  logic [HWIDTH-1:0] act_t, hs0_t, hs1_t, ox;
  logic              line_seen, line_st, vb_fall;
  logic              ry0, par, vb_fell, vs_q, vbo_q;

  // Saturating period count; on ce_pix it is the length of the pixel.
  assign pnext = (cnt == PMAX) ? PMAX : cnt + ONE_P;
  assign ph    = {1'b0, cnt} + ONE_W;
  assign q1    = per >> 2;
  assign hf    = per >> 1;
  assign q3    = hf + q1;

  // Strobes stop once the phase runs past the last expected slot.
  assign in_win = ph < {1'b0, per};
  assign hit4 = in_win & ((ph == {1'b0, q1}) |
                          (ph == {1'b0, hf}) |
                          (ph == {1'b0, q3}));
  assign hit2 = in_win & (ph == {1'b0, hf});
  assign cei  = per_vld & (ce_pix | (~merr & hit4));
  assign ceo  = per_vld & (ce_pix | (~merr & hit2));

  assign line_st = ce_pix & hb_p & ~hblank_in;
  assign vb_fall = rf_q & ~vblank_in;
  assign cur = line_st ? '0 :
               (hpos == HMAX) ? hpos : hpos + ONE_H;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      per       <= '0;
      pix_seen  <= 1'b0;
      per_vld   <= 1'b0;
      merr      <= 1'b0;
      pix_q     <= '0;
      rl_q      <= 1'b0;
      rf_q      <= 1'b0;
      hb_p      <= 1'b0;
      hs_p      <= 1'b0;
      hpos      <= '0;
      len       <= '0;
      act       <= '0;
      hs0       <= '0;
      hs1       <= '0;
      act_t     <= '0;
      hs0_t     <= '0;
      hs1_t     <= '0;
      line_seen <= 1'b0;
      ox        <= '0;
      ry0       <= 1'b0;
      par       <= 1'b0;
      vb_fell   <= 1'b0;
      vs_q      <= 1'b0;
      vbo_q     <= 1'b0;
    end else begin
      rl_q <= hblank_in;
      rf_q <= vblank_in;
      cnt  <= ce_pix ? '0 : pnext;
      if (ce_pix) begin
        per      <= pnext;
        pix_seen <= 1'b1;
        if (pix_seen) per_vld <= 1'b1;
        // First pulse after reset has no real period behind it.
        merr  <= pix_seen & (pnext < PMIN);
        pix_q <= rgb_in;
        hb_p  <= hblank_in;
        hs_p  <= hs_in;
        hpos  <= cur;
        if (~hb_p & hblank_in) act_t <= cur;
        if (~hs_p & hs_in) hs0_t <= cur;
        if (hs_p & ~hs_in) hs1_t <= cur;
        if (line_st) begin
          line_seen <= 1'b1;
          // The line cut by reset is never trusted.
          if (line_seen) begin
            len <= (hpos == HMAX) ? HMAX : hpos + ONE_H;
            act <= act_t;
            hs0 <= hs0_t;
            hs1 <= hs1_t;
          end
        end
      end
      if (line_st) begin
        ox      <= '0;
        ry0     <= 1'b0;
        vs_q    <= vs_in;
        vbo_q   <= vblank_in;
        par     <= (vb_fell | vb_fall) ? 1'b0 : ~par;
        vb_fell <= 1'b0;
      end else begin
        if (vb_fall) vb_fell <= 1'b1;
        if (ceo) begin
          if (len == '0) begin
            ox <= '0;
          end else if (ox == len - ONE_H) begin
            ox    <= '0;
            ry0   <= 1'b1;
            vs_q  <= vs_in;
            vbo_q <= vblank_in;
          end else begin
            ox <= ox + ONE_H;
          end
        end
      end
    end
  end

  assign inputpixel  = reset ? '0 : pix_q;
  assign ce_in       = ~reset & cei;
  assign ce_out      = ~reset & ceo;
  assign reset_line  = ~reset & rl_q;
  assign reset_frame = ~reset & rf_q;
  // Read the buffer the scaler finished on the previous input line.
  assign read_y      = reset ? 2'b00 : {~par, ry0};
  assign hblank_out  = ~reset & ((len == '0) | (ox >= act));
  assign hs_out      = ~reset & (len != '0) &
                       (ox >= hs0) & (ox < hs1);
  assign vs_out      = ~reset & vs_q;
  assign vblank_out  = ~reset & vbo_q;
  assign mode_err    = ~reset & merr;

`ifdef HQ2X_SCAN_STATS_EN
  logic [HWIDTH-1:0] line_cnt, st_lines;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
      st_lines <= '0;
    end else if (vb_fall) begin
      st_lines <= line_cnt;
      line_cnt <= line_st ? ONE_H : '0;
    end else if (line_st && line_cnt != HMAX) begin
      line_cnt <= line_cnt + ONE_H;
    end
  end

  assign stat_period   = reset ? '0 : per;
  assign stat_line_len = reset ? '0 : len;
  assign stat_lines    = reset ? '0 : st_lines;
`endif

endmodule
